// File: rtl/qproc_mcore_ctrl_pkg.sv
// qproc_mcore_pkg: core-state codes, opcodes and request priority for the multi-core control unit
package qproc_mcore_pkg;
  typedef enum logic [2:0] {
    C_RST_STOP      = 3'd0,
    C_RST_STOP_WAIT = 3'd1,
    C_RST_RUN       = 3'd2,
    C_RST_RUN_WAIT  = 3'd3,
    C_STOP          = 3'd4,
    C_RUN           = 3'd5,
    C_STEP          = 3'd6
  } core_st_t;
  typedef enum logic [2:0] {REQ_NONE, REQ_STOP, REQ_RUN, REQ_RST_RUN, REQ_RST_STOP, REQ_STEP} req_t;
  localparam logic [2:0] OP_RST_STOP = 3'd0;
  localparam logic [2:0] OP_RST_RUN  = 3'd1;
  localparam logic [2:0] OP_STOP     = 3'd2;
  localparam logic [2:0] OP_RUN      = 3'd3;
  localparam logic [2:0] OP_STEP     = 3'd4;
  function automatic req_t req_pri(input logic stop, input logic run, input logic rst_run,
                                   input logic rst_stop, input logic step);
    return stop ? REQ_STOP : run ? REQ_RUN : rst_run ? REQ_RST_RUN :
           rst_stop ? REQ_RST_STOP : step ? REQ_STEP : REQ_NONE;
  endfunction
endpackage

// File: rtl/qproc_core_fsm.sv
// qproc_core_fsm: one core's control FSM with step counter, flush timeout and time reference
module qproc_core_fsm
  import qproc_mcore_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int TMO_W  = 16,
  parameter int REF_W  = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  req_t              req,
  input  logic [STEP_W-1:0] step_n,
  input  logic              fifo_full,
  input  logic [TMO_W-1:0]  tmo_lim,
  input  logic              tref_en,
  input  logic              tref_inc,
  input  logic [31:0]       tref_dt,
  output logic              core_rst,
  output logic              core_en,
  output logic [2:0]        core_st,
  output logic              tmo_err,
  output logic              busy,
  output logic [REF_W-1:0]  time_ref
);
  core_st_t st, nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic in_rst, rst_req, step_go, tmo_hit, tmo_evt;
  assign in_rst  = st == C_RST_STOP || st == C_RST_RUN;
  assign rst_req = req == REQ_RST_RUN || req == REQ_RST_STOP;
  assign step_go = req == REQ_STEP && st == C_STOP;
  assign tmo_hit = tmo_lim != '0 && tmo_cnt == tmo_lim;
  // a timeout only counts as an error when no explicit request overrides the transition
  assign tmo_evt = in_rst && !fifo_full && tmo_hit && (req == REQ_NONE || req == REQ_STEP);
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= C_RST_STOP;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      C_RST_STOP:      nxt = fifo_full ? C_RST_STOP_WAIT : tmo_hit ? C_STOP : st;
      C_RST_STOP_WAIT: nxt = fifo_full ? st : C_STOP;
      C_RST_RUN:       nxt = fifo_full ? C_RST_RUN_WAIT : tmo_hit ? C_STOP : st;
      C_RST_RUN_WAIT:  nxt = fifo_full ? st : C_RUN;
      C_STEP:          nxt = (step_cnt <= STEP_W'(1)) ? C_STOP : st;
      default:         nxt = st;
    endcase
    nxt = req == REQ_STOP ? C_STOP : req == REQ_RUN ? C_RUN : req == REQ_RST_RUN ? C_RST_RUN :
          req == REQ_RST_STOP ? C_RST_STOP : step_go ? C_STEP : nxt;
  end
  always_comb begin
    core_rst = in_rst;
    core_en  = st == C_RUN || st == C_STEP;
    core_st  = st;
    busy     = st != C_STOP && st != C_RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step_cnt <= '0;
      tmo_cnt  <= '0;
      tmo_err  <= 1'b0;
      time_ref <= '0;
    end else begin
      step_cnt <= step_go ? (step_n == '0 ? STEP_W'(1) : step_n) :
                  st == C_STEP ? step_cnt - STEP_W'(1) : step_cnt;
      tmo_cnt  <= rst_req ? '0 : (in_rst && !fifo_full) ? tmo_cnt + TMO_W'(1) : tmo_cnt;
      tmo_err  <= rst_req ? 1'b0 : tmo_evt ? 1'b1 : tmo_err;
      time_ref <= core_rst ? '0 : !tref_en ? time_ref :
                  tref_inc ? time_ref + REF_W'(tref_dt) : REF_W'(tref_dt);
    end
endmodule

// File: rtl/qproc_mcore_ctrl.sv
// qproc_mcore_ctrl: per-core command decode, net gating and busy reduction over NCORE core FSMs
module qproc_mcore_ctrl
  import qproc_mcore_pkg::*;
#(
  parameter int NCORE  = 2,
  parameter int STEP_W = 8,
  parameter int TMO_W  = 16,
  parameter int REF_W  = 48
) (
  input  logic                   c_clk_i,
  input  logic                   c_rst_i,
  input  logic                   cmd_vld_i,
  input  logic [2:0]             cmd_op_i,
  input  logic [NCORE-1:0]       cmd_mask_i,
  input  logic [STEP_W-1:0]      step_n_i,
  input  logic                   net_en_i,
  input  logic                   net_start_i,
  input  logic                   net_stop_i,
  input  logic [NCORE-1:0]       fifo_full_i,
  input  logic [TMO_W-1:0]       tmo_lim_i,
  input  logic [NCORE-1:0]       tref_en_i,
  input  logic                   tref_inc_i,
  input  logic [31:0]            tref_dt_i,
  output logic [NCORE-1:0]       core_rst_o,
  output logic [NCORE-1:0]       core_en_o,
  output logic [3*NCORE-1:0]     core_st_o,
  output logic [NCORE-1:0]       tmo_err_o,
  output logic                   busy_o,
  output logic [REF_W*NCORE-1:0] c_time_ref_o
);
  logic [NCORE-1:0] busy;
  logic net_stop, net_start;
  assign net_stop  = net_en_i && net_stop_i;
  assign net_start = net_en_i && net_start_i;
  for (genvar g = 0; g < NCORE; g++) begin : g_core
    logic hit;
    req_t req;
    assign hit = cmd_vld_i && cmd_mask_i[g];
    assign req = req_pri(hit && cmd_op_i == OP_STOP || net_stop, hit && cmd_op_i == OP_RUN,
                         hit && cmd_op_i == OP_RST_RUN || net_start,
                         hit && cmd_op_i == OP_RST_STOP, hit && cmd_op_i == OP_STEP);
    qproc_core_fsm #(.STEP_W(STEP_W), .TMO_W(TMO_W), .REF_W(REF_W)) u_fsm (
      .clk      (c_clk_i),
      .rst      (c_rst_i),
      .req      (req),
      .step_n   (step_n_i),
      .fifo_full(fifo_full_i[g]),
      .tmo_lim  (tmo_lim_i),
      .tref_en  (tref_en_i[g]),
      .tref_inc (tref_inc_i),
      .tref_dt  (tref_dt_i),
      .core_rst (core_rst_o[g]),
      .core_en  (core_en_o[g]),
      .core_st  (core_st_o[3*g +: 3]),
      .tmo_err  (tmo_err_o[g]),
      .busy     (busy[g]),
      .time_ref (c_time_ref_o[REF_W*g +: REF_W])
    );
  end
  assign busy_o = |busy;
endmodule

// File: tb/tb_qproc_mcore_ctrl.sv
// tb_qproc_mcore_ctrl: directed self-checking bench for the multi-core control unit
module tb_qproc_mcore_ctrl;
  logic c_clk = 1'b0, c_rst = 1'b1;
  logic cmd_vld = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_mask = '0;
  logic [7:0] step_n = '0;
  logic net_en = 1'b0, net_start = 1'b0, net_stop = 1'b0;
  logic [1:0] fifo_full = '0;
  logic [15:0] tmo_lim = '0;
  logic [1:0] tref_en = '0;
  logic tref_inc = 1'b0;
  logic [31:0] tref_dt = '0;
  logic [1:0] core_rst, core_en, tmo_err;
  logic [5:0] core_st;
  logic busy;
  logic [95:0] tref;
  int total = 0, bad = 0;

  qproc_mcore_ctrl dut (
    .c_clk_i(c_clk), .c_rst_i(c_rst), .cmd_vld_i(cmd_vld), .cmd_op_i(cmd_op),
    .cmd_mask_i(cmd_mask), .step_n_i(step_n), .net_en_i(net_en), .net_start_i(net_start),
    .net_stop_i(net_stop), .fifo_full_i(fifo_full), .tmo_lim_i(tmo_lim), .tref_en_i(tref_en),
    .tref_inc_i(tref_inc), .tref_dt_i(tref_dt), .core_rst_o(core_rst), .core_en_o(core_en),
    .core_st_o(core_st), .tmo_err_o(tmo_err), .busy_o(busy), .c_time_ref_o(tref)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] mask);
    cmd_vld = 1'b1; cmd_op = op; cmd_mask = mask;
    tick(1);
    cmd_vld = 1'b0;
  endtask

  initial begin
    tick(2);
    chk("rst_st", 64'(core_st), 64'h0);
    chk("rst_core_rst", 64'(core_rst), 64'h3);
    chk("rst_en", 64'(core_en), 64'h0);
    chk("rst_tmo", 64'(tmo_err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h1);
    chk("rst_tref", tref[63:0], 64'h0);
    c_rst = 1'b0;
    // flush handshake on core0
    tick(5);
    chk("flush_st0_pre", 64'(core_st[2:0]), 64'd0);
    chk("flush_rst0_pre", 64'(core_rst[0]), 64'd1);
    fifo_full = 2'b01;
    tick(1);
    chk("flush_st0_wait", 64'(core_st[2:0]), 64'd1);
    chk("flush_rst0_wait", 64'(core_rst[0]), 64'd0);
    tick(2);
    chk("flush_st0_hold", 64'(core_st[2:0]), 64'd1);
    fifo_full = 2'b00;
    tick(1);
    chk("flush_st0_stop", 64'(core_st[2:0]), 64'd4);
    chk("flush_busy", 64'(busy), 64'd1);
    // STEP 3
    step_n = 8'd3;
    issue(3'd4, 2'b01);
    chk("step3_st", 64'(core_st[2:0]), 64'd6);
    chk("step3_en1", 64'(core_en[0]), 64'd1);
    tick(1);
    chk("step3_en2", 64'(core_en[0]), 64'd1);
    tick(1);
    chk("step3_en3", 64'(core_en[0]), 64'd1);
    tick(1);
    chk("step3_end_en", 64'(core_en[0]), 64'd0);
    chk("step3_end_st", 64'(core_st[2:0]), 64'd4);
    // STEP 0 behaves as one cycle
    step_n = 8'd0;
    issue(3'd4, 2'b01);
    chk("step0_en1", 64'(core_en[0]), 64'd1);
    tick(1);
    chk("step0_end_en", 64'(core_en[0]), 64'd0);
    chk("step0_end_st", 64'(core_st[2:0]), 64'd4);
    // flush timeout on core1
    tmo_lim = 16'd10;
    issue(3'd1, 2'b10);
    chk("tmo_st1_rst", 64'(core_st[5:3]), 64'd2);
    chk("tmo_rst1", 64'(core_rst[1]), 64'd1);
    tick(10);
    chk("tmo_st1_pre", 64'(core_st[5:3]), 64'd2);
    chk("tmo_err_pre", 64'(tmo_err[1]), 64'd0);
    tick(1);
    chk("tmo_st1_stop", 64'(core_st[5:3]), 64'd4);
    chk("tmo_err_set", 64'(tmo_err[1]), 64'd1);
    chk("tmo_st0_kept", 64'(core_st[2:0]), 64'd4);
    issue(3'd1, 2'b10);
    chk("tmo_err_clr", 64'(tmo_err[1]), 64'd0);
    chk("tmo_st1_again", 64'(core_st[5:3]), 64'd2);
    tmo_lim = 16'd0;
    // STOP beats RUN, net gating
    net_en = 1'b1; net_stop = 1'b1;
    issue(3'd3, 2'b11);
    chk("pri_stop", 64'(core_st), {58'd0, 3'd4, 3'd4});
    net_en = 1'b0;
    issue(3'd3, 2'b11);
    chk("pri_run", 64'(core_st), {58'd0, 3'd5, 3'd5});
    chk("run_en", 64'(core_en), 64'h3);
    chk("run_busy", 64'(busy), 64'd0);
    net_stop = 1'b0;
    step_n = 8'd4;
    issue(3'd4, 2'b01);
    chk("step_ignored", 64'(core_st[2:0]), 64'd5);
    // time reference
    tref_en = 2'b11; tref_inc = 1'b0; tref_dt = 32'hFFFF_FFFF;
    tick(1);
    chk("tref_set", 64'(tref[47:0]), 64'h0000_FFFF_FFFF);
    tref_inc = 1'b1; tref_dt = 32'd1;
    tick(1);
    tref_en = 2'b00;
    chk("tref_inc", 64'(tref[47:0]), 64'h0001_0000_0000);
    issue(3'd0, 2'b01);
    chk("tref_rst_lat", 64'(tref[47:0]), 64'h0001_0000_0000);
    chk("tref_core_rst", 64'(core_rst[0]), 64'd1);
    tick(1);
    chk("tref_clr", 64'(tref[47:0]), 64'h0);
    chk("tref1_kept", 64'(tref[95:48]), 64'h0001_0000_0000);
    // async reset mid-STEP
    issue(3'd2, 2'b01);
    chk("pre_step_st", 64'(core_st[2:0]), 64'd4);
    step_n = 8'd8;
    issue(3'd4, 2'b01);
    tick(3);
    chk("mid_step_st", 64'(core_st[2:0]), 64'd6);
    c_rst = 1'b1;
    #1;
    chk("arst_st", 64'(core_st), 64'h0);
    chk("arst_core_rst", 64'(core_rst), 64'h3);
    chk("arst_en", 64'(core_en), 64'h0);
    chk("arst_busy", 64'(busy), 64'd1);
    chk("arst_tref", tref[95:48], 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
